// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared state encodings and datapath width for the CPU slice.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bit_counter
// Brief    : Up-counter with enable, synchronous clear and terminal-count flag.
// Revision : 1.0
// ============================================================================
module bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [c_CNT_W-1:0] r_count;

    // Saturates at WIDTH-1 so the count can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == c_CNT_W'(WIDTH - 1));

endmodule : bit_counter
`default_nettype wire

// File: rtl/piso_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_register
// Brief    : Parallel-in serial-out register; loads a word and emits one bit
//            per enabled clock, pulsing done after the last bit.
// Revision : 1.0
// ============================================================================
module piso_shift_register
    import cpu_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             shift_en,
    output logic             ready,
    output logic             busy,
    output logic             d_out,
    output logic             bit_valid,
    output logic             done
);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_shifted;
    logic             w_head;
    logic             w_tc;
    logic             w_load_accept;
    logic             w_advance;

    assign w_load_accept = (r_state == S_IDLE) && load;
    assign w_advance     = (r_state == S_SHIFT) && shift_en && !w_tc;

    // Head bit and shift direction depend on transmit order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head    = r_sreg[WIDTH-1];
            assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head    = r_sreg[0];
            assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg <= '0;
        end else if (w_load_accept) begin
            r_sreg <= d_in;
        end else if (w_advance) begin
            r_sreg <= w_shifted;
        end
    end

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (w_load_accept),
        .en  (w_advance),
        .tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (load) w_next_state = S_SHIFT;
            S_SHIFT: if (shift_en && w_tc) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs decode state and stored data only; no input reaches them.
    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        bit_valid = 1'b0;
        done      = 1'b0;
        d_out     = 1'b0;
        case (r_state)
            S_IDLE: ready = 1'b1;
            S_SHIFT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                d_out     = w_head;
            end
            S_DONE:  done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule : piso_shift_register
`default_nettype wire

// File: tb/tb_piso_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_shift_register
// Brief    : Bench driving MSB-first and LSB-first instances side by side
//            against a word/position reference model.
// Revision : 1.0
// ============================================================================
module tb_piso_shift_register;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic         shift_en = 1'b0;
    logic [W-1:0] d_in = '0;

    logic ready_m, busy_m, d_out_m, bit_valid_m, done_m;
    logic ready_l, busy_l, d_out_l, bit_valid_l, done_l;

    int errors = 0;
    int checks = 0;

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .d_in      (d_in),
        .shift_en  (shift_en),
        .ready     (ready_m),
        .busy      (busy_m),
        .d_out     (d_out_m),
        .bit_valid (bit_valid_m),
        .done      (done_m)
    );

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .d_in      (d_in),
        .shift_en  (shift_en),
        .ready     (ready_l),
        .busy      (busy_l),
        .d_out     (d_out_l),
        .bit_valid (bit_valid_l),
        .done      (done_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = sending bit m_pos of m_word, 2 = done.
    int           m_mode = 0;
    int           m_pos  = 0;
    logic [W-1:0] m_word = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0;
            m_pos  = 0;
            m_word = '0;
        end else begin
            case (m_mode)
                0: if (load) begin
                    m_word = d_in;
                    m_pos  = 0;
                    m_mode = 1;
                end
                1: if (shift_en) begin
                    if (m_pos == W - 1) m_mode = 2;
                    else m_pos = m_pos + 1;
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic exp_m, exp_l;
        exp_m = (m_mode == 1) ? m_word[W-1-m_pos] : 1'b0;
        exp_l = (m_mode == 1) ? m_word[m_pos] : 1'b0;
        chk("msb_ready",     {31'd0, ready_m},     {31'd0, m_mode == 0});
        chk("msb_busy",      {31'd0, busy_m},      {31'd0, m_mode == 1});
        chk("msb_bit_valid", {31'd0, bit_valid_m}, {31'd0, m_mode == 1});
        chk("msb_done",      {31'd0, done_m},      {31'd0, m_mode == 2});
        chk("msb_d_out",     {31'd0, d_out_m},     {31'd0, exp_m});
        chk("lsb_ready",     {31'd0, ready_l},     {31'd0, m_mode == 0});
        chk("lsb_busy",      {31'd0, busy_l},      {31'd0, m_mode == 1});
        chk("lsb_done",      {31'd0, done_l},      {31'd0, m_mode == 2});
        chk("lsb_d_out",     {31'd0, d_out_l},     {31'd0, exp_l});
    end

    // Called at posedge+2. Loads w, stalls cycles [st_start, st_start+st_len),
    // optionally attempts a second load of busy_w in cycle 3.
    task automatic run_word(input logic [W-1:0] w, input int st_start, input int st_len,
                            input logic [W-1:0] busy_w, output logic [W-1:0] got_m,
                            output logic [W-1:0] got_l, output int lat);
        int k;
        logic [W-1:0] wv;
        wv = w;
        k  = 0;
        while (!ready_m && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        if (k >= 50) chk("ready_timeout", 32'd0, 32'd1);
        load = 1'b1; d_in = w; shift_en = 1'b1;
        @(posedge clk); #2;
        load = 1'b0; d_in = W'($urandom);
        got_m = '0; got_l = '0; lat = 0;
        for (int c = 1; c <= 40; c++) begin
            shift_en = !(c >= st_start && c < st_start + st_len);
            if (busy_w != '0 && c == 3) begin
                load = 1'b1; d_in = busy_w;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            if (done_m) begin
                lat = c;
                break;
            end
            if (bit_valid_m && !shift_en)
                chk("stall_hold", {31'd0, d_out_m}, {31'd0, wv[W-st_start]});
            if (bit_valid_m && shift_en) begin
                got_m = {got_m[W-2:0], d_out_m};
                got_l = {d_out_l, got_l[W-1:1]};
            end
            @(posedge clk); #2;
        end
        load = 1'b0; shift_en = 1'b0;
        @(negedge clk);
        chk("ready_after_done", {31'd0, ready_m}, 32'd1);
        @(posedge clk); #2;
    endtask

    initial begin
        logic [W-1:0] gm, gl;
        int           lat;

        // Asynchronous reset, observed without any clock edge.
        #3 rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready_m}, 32'd1);
        chk("rst_busy",  {31'd0, busy_m},  32'd0);
        chk("rst_dout",  {31'd0, d_out_m}, 32'd0);
        chk("rst_valid", {31'd0, bit_valid_m}, 32'd0);
        chk("rst_done",  {31'd0, done_l},  32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #2;

        run_word(8'hA5, 0, 0, 8'h00, gm, gl, lat);
        chk("a5_msb_word", {24'd0, gm}, 32'hA5);
        chk("a5_lsb_word", {24'd0, gl}, 32'hA5);
        chk("a5_latency",  lat, 9);

        run_word(8'h01, 0, 0, 8'h00, gm, gl, lat);
        chk("01_msb_word", {24'd0, gm}, 32'h01);
        chk("01_lsb_word", {24'd0, gl}, 32'h01);

        run_word(8'hF0, 3, 3, 8'h00, gm, gl, lat);
        chk("f0_stall_word", {24'd0, gm}, 32'hF0);
        chk("f0_stall_lsb",  {24'd0, gl}, 32'hF0);
        chk("f0_stall_latency", lat, 12);

        run_word(8'hA5, 0, 0, 8'h3C, gm, gl, lat);
        chk("busy_load_ignored", {24'd0, gm}, 32'hA5);
        run_word(8'h3C, 0, 0, 8'h00, gm, gl, lat);
        chk("3c_msb_word", {24'd0, gm}, 32'h3C);
        chk("3c_lsb_word", {24'd0, gl}, 32'h3C);

        // Abort 8'hFF after four bits with a mid-cycle reset.
        load = 1'b1; d_in = 8'hFF; shift_en = 1'b1;
        @(posedge clk); #2;
        load = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
        end
        #1 rst = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, busy_m},  32'd0);
        chk("abort_ready", {31'd0, ready_l}, 32'd1);
        chk("abort_done",  {31'd0, done_m},  32'd0);
        chk("abort_dout",  {31'd0, d_out_m}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("abort_no_done", {31'd0, done_m}, 32'd0);
        @(posedge clk); #2;
        run_word(8'h81, 0, 0, 8'h00, gm, gl, lat);
        chk("81_msb_word", {24'd0, gm}, 32'h81);
        chk("81_lsb_word", {24'd0, gl}, 32'h81);
        chk("81_latency",  lat, 9);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            load     = ($urandom_range(0, 3) == 0);
            d_in     = W'($urandom);
            shift_en = ($urandom_range(0, 3) != 0);
            @(posedge clk); #2;
        end
        load = 1'b0; shift_en = 1'b1;
        repeat (12) begin
            @(posedge clk); #2;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_piso_shift_register
`default_nettype wire
